// File: rtl/csa_sequencer_pkg.sv
// Shared definitions for the carry-save multi-operand adder blocks.
package csa_sequencer_pkg;

  localparam int unsigned CSA_WIDTH = 23;
  localparam int unsigned CSA_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_DONE    = 2'd3
  } csa_state_e;

endpackage : csa_sequencer_pkg

// File: rtl/csa_sequencer_if.sv
// Job, operand-stream and result handshake bundle for the CSA sequencer.
interface csa_sequencer_if
  import csa_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = CSA_WIDTH,
  parameter int unsigned CNT_W = CSA_CNT_W
) ();

  logic             start;
  logic [CNT_W-1:0] count;
  logic             op_valid;
  logic [WIDTH-1:0] op_data;
  logic             op_ready;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] result;
  logic             busy;

  modport master (
    output start, count, op_valid, op_data, res_ready,
    input  op_ready, res_valid, result, busy
  );

  modport slave (
    input  start, count, op_valid, op_data, res_ready,
    output op_ready, res_valid, result, busy
  );

endinterface : csa_sequencer_if

// File: rtl/csa_sequencer_csa_block.sv
// 3:2 compressor row: full adder per bit, carry vector pre-shifted left by one.
module csa_block #(
  parameter int unsigned WIDTH = 23
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  output logic [WIDTH-1:0] sum_c_o,
  output logic [WIDTH-1:0] carry_c_o
);

  logic [WIDTH-1:0] maj;

  assign sum_c_o   = a_i ^ b_i ^ c_i;
  assign maj       = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  // MSB carry is dropped: arithmetic wraps modulo 2^WIDTH.
  assign carry_c_o = {maj[WIDTH-2:0], 1'b0};

endmodule : csa_block

// File: rtl/csa_sequencer.sv
// Accumulates a counted stream of operands in carry-save form, then resolves
// S+C with one carry-propagate add and holds the result until consumed.
module csa_sequencer
  import csa_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = CSA_WIDTH,
  parameter int unsigned CNT_W = CSA_CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  csa_sequencer_if.slave  bus
);

  csa_state_e       state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             op_ready_q;
  logic             res_valid_q;
  logic             busy_q;

  logic [WIDTH-1:0] csa_sum;
  logic [WIDTH-1:0] csa_carry;

  csa_block #(.WIDTH(WIDTH)) u_csa (
    .a_i       (s_q),
    .b_i       (c_q),
    .c_i       (bus.op_data),
    .sum_c_o   (csa_sum),
    .carry_c_o (csa_carry)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    c_d      = c_q;
    rem_d    = rem_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          s_d = '0;
          c_d = '0;
          if (bus.count != '0) begin
            rem_d   = bus.count;
            state_d = ST_ACCUM;
          end else begin
            rem_d   = '0;
            state_d = ST_RESOLVE;
          end
        end
      end
      ST_ACCUM: begin
        if (bus.op_valid) begin
          s_d   = csa_sum;
          c_d   = csa_carry;
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = ST_RESOLVE;
          end
        end
      end
      ST_RESOLVE: begin
        result_d = s_q + c_q;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (bus.res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and status-flag registers; flags mirror the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      s_q         <= '0;
      c_q         <= '0;
      rem_q       <= '0;
      result_q    <= '0;
      op_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      c_q         <= c_d;
      rem_q       <= rem_d;
      result_q    <= result_d;
      op_ready_q  <= (state_d == ST_ACCUM);
      res_valid_q <= (state_d == ST_DONE);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign bus.op_ready  = op_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.busy      = busy_q;
  assign bus.result    = result_q;

endmodule : csa_sequencer

// File: tb/tb_csa_sequencer.sv
// Scoreboard bench for csa_sequencer: expected sums are queued as operands are
// streamed and compared when the result handshake completes.
module tb_csa_sequencer;
  import csa_sequencer_pkg::*;

  localparam int unsigned W  = CSA_WIDTH;
  localparam int unsigned CW = CSA_CNT_W;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  csa_sequencer_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  csa_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_acc;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Result monitor: pop and compare on every completed result handshake.
  always @(negedge clk) begin
    if (!rst && bus.res_valid && bus.res_ready) begin
      check_val("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check_val("result", 32'(bus.result), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_job(input int cnt);
    model_acc = '0;
    bus.start = 1'b1;
    bus.count = CW'(cnt);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_op(input logic [W-1:0] d);
    int n;
    n = 0;
    bus.op_valid = 1'b1;
    bus.op_data  = d;
    forever begin
      @(negedge clk);
      if (bus.op_ready) break;
      n++;
      if (n > 50) begin
        check_val("op_ready_timeout", 32'(bus.op_ready), 32'd1);
        break;
      end
    end
    tick();
    model_acc    = model_acc + d;
    bus.op_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Wait for res_valid, let the handshake happen, confirm return to IDLE.
  task automatic finish_job();
    int n;
    n = 0;
    while (!bus.res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("res_valid_seen", 32'(bus.res_valid), 32'd1);
    tick();
    @(negedge clk);
    check_val("idle_busy", 32'(bus.busy), 32'd0);
    check_val("idle_res_valid", 32'(bus.res_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.count    = '0;
    bus.op_valid = 1'b0;
    bus.op_data  = '0;
    bus.res_ready = 1'b1;
    model_acc    = '0;

    // Reset state.
    @(negedge clk);
    check_val("rst_op_ready", 32'(bus.op_ready), 32'd0);
    check_val("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_result", 32'(bus.result), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Basic sum 1..9 back-to-back with latency check.
    begin_job(9);
    check_val("accum_busy", 32'(bus.busy), 32'd1);
    for (int i = 1; i <= 9; i++) send_op(W'(i));
    exp_q.push_back(model_acc);
    @(negedge clk);
    check_val("lat_resolve", 32'(bus.res_valid), 32'd0);
    @(negedge clk);
    check_val("lat_done", 32'(bus.res_valid), 32'd1);
    check_val("sum45", 32'(bus.result), 32'd45);
    finish_job();

    // Wrap-around cases.
    begin_job(2);
    send_op(23'h7FFFFF);
    send_op(23'h000001);
    exp_q.push_back(model_acc);
    finish_job();

    begin_job(3);
    repeat (3) send_op(23'h7FFFFF);
    exp_q.push_back(model_acc);
    check_val("wrap3_model", 32'(model_acc), 32'h7FFFFD);
    finish_job();

    // Gapped operands with res_ready held low for 5 cycles.
    bus.res_ready = 1'b0;
    begin_job(4);
    send_op(23'h012345);
    idle(2);
    send_op(23'h00ABCD);
    send_op(23'h400000);
    idle(1);
    send_op(23'h3FFFFF);
    exp_q.push_back(model_acc);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check_val("hold_res_valid", 32'(bus.res_valid), 32'd1);
      check_val("hold_result", 32'(bus.result), 32'(model_acc));
      check_val("hold_op_ready", 32'(bus.op_ready), 32'd0);
      if (k < 4) @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.res_ready = 1'b1;
    finish_job();

    // Zero-count job.
    begin_job(0);
    exp_q.push_back(model_acc);
    @(negedge clk);
    check_val("zero_resolve", 32'(bus.res_valid), 32'd0);
    @(negedge clk);
    check_val("zero_done", 32'(bus.res_valid), 32'd1);
    finish_job();

    // start pulsed during ACCUM must not re-latch count.
    begin_job(3);
    send_op(W'(100));
    bus.start = 1'b1;
    bus.count = CW'(7);
    tick();
    bus.start = 1'b0;
    send_op(W'(200));
    send_op(W'(300));
    exp_q.push_back(model_acc);
    @(negedge clk);
    check_val("ign_resolve", 32'(bus.res_valid), 32'd0);
    @(negedge clk);
    check_val("ign_done", 32'(bus.res_valid), 32'd1);
    finish_job();

    // Reset after 3 of 5 operands; previous result (600) must clear.
    begin_job(5);
    send_op(W'(7));
    send_op(W'(8));
    send_op(W'(9));
    #2;
    rst = 1'b1;
    #1;
    check_val("mid_rst_op_ready", 32'(bus.op_ready), 32'd0);
    check_val("mid_rst_res_valid", 32'(bus.res_valid), 32'd0);
    check_val("mid_rst_busy", 32'(bus.busy), 32'd0);
    check_val("mid_rst_result", 32'(bus.result), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();

    begin_job(2);
    send_op(W'(10));
    send_op(W'(20));
    exp_q.push_back(model_acc);
    check_val("post_rst_model", 32'(model_acc), 32'd30);
    finish_job();

    check_val("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_csa_sequencer
